// File: rtl/ar_out_credit_buffer_if.sv
// AR channel bundle: request fields plus valid/ready.
// valid/ready: a transfer happens on a posedge where both are high; once valid
// is raised the sender holds valid and every field stable until that transfer.
interface ar_if #(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int SIZE_WIDTH  = 3,
  parameter int BURST_WIDTH = 2,
  parameter int QOS_WIDTH   = 4
) ();
  logic                   valid;
  logic                   ready;
  logic [ID_WIDTH-1:0]    id;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [LEN_WIDTH-1:0]   len;
  logic [SIZE_WIDTH-1:0]  size;
  logic [BURST_WIDTH-1:0] burst;
  logic [QOS_WIDTH-1:0]   qos;

  modport receiver (
    input  valid, id, addr, len, size, burst, qos,
    output ready
  );

  modport sender (
    output valid, id, addr, len, size, burst, qos,
    input  ready
  );
endinterface

// File: rtl/ar_out_credit_buffer.sv
// Outgoing AR buffer: FIFO plus a stable output register, empty-bypass,
// outstanding-read credit throttling, synchronous flush and occupancy status.
module ar_out_credit_buffer #(
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 8,
  parameter int SIZE_WIDTH      = 3,
  parameter int BURST_WIDTH     = 2,
  parameter int QOS_WIDTH       = 4,
  parameter int DEPTH           = 8,
  parameter int AFULL_THRESH    = 6,
  parameter int MAX_OUTSTANDING = 16,
  localparam int CNT_W          = $clog2(DEPTH + 1),
  localparam int OST_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  ar_if.receiver           ar_in,
  ar_if.sender             ar_out,
  input  logic             r_done,
  input  logic             flush,
  output logic             buffer_full,
  output logic             buffer_almost_full,
  output logic [CNT_W-1:0] occupancy,
  output logic [OST_W-1:0] outstanding,
  output logic             throttled
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PW    = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH
                       + BURST_WIDTH + QOS_WIDTH;

  logic [PW-1:0]    mem [DEPTH];
  logic [PW-1:0]    pay_in;
  logic [PW-1:0]    out_pay_q, out_pay_d;
  logic             out_valid_q, out_valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occupancy_q, occupancy_d;
  logic [OST_W-1:0] outstanding_q, outstanding_d;

  logic in_ready, push, slot_free, credit_ok, fifo_empty;
  logic load, pop, bypass, fifo_wr, r_done_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pay_in = {ar_in.id, ar_in.addr, ar_in.len, ar_in.size,
                   ar_in.burst, ar_in.qos};

  always_comb begin
    fifo_empty = (occupancy_q == '0);
    in_ready   = rst_n & ~buffer_full & ~flush;
    push       = ar_in.valid & in_ready;
    slot_free  = ~out_valid_q | ar_out.ready;
    credit_ok  = (outstanding_q < OST_W'(MAX_OUTSTANDING));
    // Nothing leaves the FIFO in the flush cycle; the ORG itself is untouched.
    load       = slot_free & credit_ok & ~flush & (~fifo_empty | push);
    pop        = load & ~fifo_empty;
    bypass     = load & fifo_empty;
    fifo_wr    = push & ~bypass;
    // A completion with nothing outstanding is dropped rather than wrapping.
    r_done_eff = r_done & (outstanding_q != '0);
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occupancy_d   = occupancy_q;
    outstanding_d = outstanding_q;
    out_pay_d     = out_pay_q;
    out_valid_d   = load | (out_valid_q & ~ar_out.ready);

    if (fifo_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({fifo_wr, pop})
      2'b10:   occupancy_d = occupancy_q + CNT_W'(1);
      2'b01:   occupancy_d = occupancy_q - CNT_W'(1);
      default: occupancy_d = occupancy_q;
    endcase

    case ({load, r_done_eff})
      2'b10:   outstanding_d = outstanding_q + OST_W'(1);
      2'b01:   outstanding_d = outstanding_q - OST_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (pop)         out_pay_d = mem[rd_ptr_q];
    else if (bypass) out_pay_d = pay_in;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occupancy_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occupancy_q   <= '0;
      outstanding_q <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occupancy_q   <= occupancy_d;
      outstanding_q <= outstanding_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by the flops above.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr_q] <= pay_in;
    out_pay_q <= out_pay_d;
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(r_done && outstanding_q == '0));
  end

  assign ar_in.ready        = in_ready;
  assign ar_out.valid       = out_valid_q;
  assign {ar_out.id, ar_out.addr, ar_out.len, ar_out.size,
          ar_out.burst, ar_out.qos} = out_pay_q;
  assign buffer_full        = (occupancy_q == CNT_W'(DEPTH));
  assign buffer_almost_full = (occupancy_q >= CNT_W'(AFULL_THRESH));
  assign occupancy          = occupancy_q;
  assign outstanding        = outstanding_q;
  assign throttled          = (~fifo_empty | ar_in.valid) & slot_free & ~credit_ok;

endmodule

// File: tb/tb_ar_out_credit_buffer.sv
// Bench for ar_out_credit_buffer: directed scenarios plus random traffic,
// checked against a queue-based model and an in-order expected queue.
module tb_ar_out_credit_buffer;
  localparam int ID_W  = 4;
  localparam int AW    = 32;
  localparam int LW    = 8;
  localparam int SW    = 3;
  localparam int BW    = 2;
  localparam int QW    = 4;
  localparam int DEPTH = 5;
  localparam int AFULL = 4;
  localparam int MAXO  = 3;
  localparam int PW    = ID_W + AW + LW + SW + BW + QW;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OST_W = $clog2(MAXO + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             r_done, flush;
  logic             buffer_full, buffer_almost_full, throttled;
  logic [CNT_W-1:0] occupancy;
  logic [OST_W-1:0] outstanding;

  ar_if #(.ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW),
          .BURST_WIDTH(BW), .QOS_WIDTH(QW)) in_if ();
  ar_if #(.ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW),
          .BURST_WIDTH(BW), .QOS_WIDTH(QW)) out_if ();

  ar_out_credit_buffer #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW),
    .BURST_WIDTH(BW), .QOS_WIDTH(QW), .DEPTH(DEPTH), .AFULL_THRESH(AFULL),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ar_in(in_if), .ar_out(out_if),
    .r_done(r_done), .flush(flush), .buffer_full(buffer_full),
    .buffer_almost_full(buffer_almost_full), .occupancy(occupancy),
    .outstanding(outstanding), .throttled(throttled)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] m_fifo[$];
  bit            m_ov;
  logic [PW-1:0] m_org;
  int            m_ost;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] dut_pay();
    return {out_if.id, out_if.addr, out_if.len, out_if.size, out_if.burst, out_if.qos};
  endfunction

  function automatic logic [PW-1:0] rnd_pay(input int id);
    logic [AW-1:0] a;
    a = $urandom;
    return {ID_W'(id), a, LW'($urandom), SW'($urandom), BW'($urandom), QW'($urandom)};
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_ov  = 1'b0;
    m_org = '0;
    m_ost = 0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input bit v, input logic [PW-1:0] p, input bit ordy,
                       input bit rd, input bit fl);
    int occ, ost0;
    bit full, sf, cred, push, load;
    @(negedge clk);
    in_if.valid = v;
    {in_if.id, in_if.addr, in_if.len, in_if.size, in_if.burst, in_if.qos} = p;
    out_if.ready = ordy;
    r_done = rd;
    flush  = fl;
    #1;
    occ  = m_fifo.size();
    full = (occ == DEPTH);
    sf   = !m_ov || ordy;
    cred = (m_ost < MAXO);
    chk("in_ready", in_if.ready, !full && !fl);
    chk("out_valid", out_if.valid, m_ov);
    if (m_ov) chk("out_payload", dut_pay(), m_org);
    chk("occupancy", occupancy, occ);
    chk("outstanding", outstanding, m_ost);
    chk("full", buffer_full, full);
    chk("almost_full", buffer_almost_full, occ >= AFULL);
    chk("throttled", throttled, (occ != 0 || v) && sf && !cred);
    if (out_if.valid && ordy) begin
      chk("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("sb_order", dut_pay(), exp_q.pop_front());
    end
    push = v && !full && !fl;
    if (push) exp_q.push_back(p);
    load = !fl && sf && cred && (occ != 0 || push);
    if (load) begin
      if (occ != 0) begin
        m_org = m_fifo.pop_front();
        if (push) m_fifo.push_back(p);
      end else begin
        m_org = p;
      end
      m_ov = 1'b1;
    end else begin
      if (push) m_fifo.push_back(p);
      if (m_ov && ordy) m_ov = 1'b0;
    end
    if (fl) begin
      m_fifo.delete();
      exp_q.delete();
      if (m_ov) exp_q.push_back(m_org);
    end
    ost0  = m_ost;
    m_ost = ost0 + int'(load) - int'(rd && ost0 > 0);
  endtask

  task automatic idle_drain();
    bit done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      cycle(1'b0, '0, 1'b1, m_ost > 0, 1'b0);
      done = !m_ov && m_fifo.size() == 0 && m_ost == 0;
    end
    chk("drain_done", done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_if.ready, 0);
    chk({tag, "_out_valid"}, out_if.valid, 0);
    chk({tag, "_occupancy"}, occupancy, 0);
    chk({tag, "_outstanding"}, outstanding, 0);
    chk({tag, "_full"}, buffer_full, 0);
    chk({tag, "_afull"}, buffer_almost_full, 0);
    chk({tag, "_throttled"}, throttled, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, k;
    logic [PW-1:0] p;
    in_if.valid = 1'b0;
    {in_if.id, in_if.addr, in_if.len, in_if.size, in_if.burst, in_if.qos} = '0;
    out_if.ready = 1'b0;
    r_done = 1'b0;
    flush  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single request through the bypass path
    p = {ID_W'(1), 32'h0000_0100, LW'(3), SW'(2), BW'(1), QW'(0)};
    cycle(1'b1, p, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("single_addr", out_if.addr, 32'h100);
    chk("single_ost", outstanding, 1);
    chk("single_occ", occupancy, 0);
    idle_drain();

    // fill to full with the slave stalled, then drain across pointer wrap
    n = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, rnd_pay(n), 1'b0, 1'b0, 1'b0);
      if (in_if.ready) n++;
    end
    chk("fill_accepted", n, DEPTH + 1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("fill_full", buffer_full, 1);
    chk("fill_afull", buffer_almost_full, 1);
    chk("fill_ready", in_if.ready, 0);
    for (int c = 0; c < 40; c++) begin
      cycle(n < 16, rnd_pay(n), 1'b1, (m_ost > 0) && ($urandom_range(0, 1) == 1), 1'b0);
      if (n < 16 && in_if.ready) n++;
    end
    idle_drain();

    // credit throttle: no completions, so only MAXO requests issue
    k = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(k < 6, rnd_pay(k), 1'b1, 1'b0, 1'b0);
      if (k < 6 && in_if.ready) k++;
    end
    chk("thr_ost", outstanding, MAXO);
    chk("thr_flag", throttled, 1);
    chk("thr_occ", occupancy, 6 - MAXO);
    idle_drain();

    // flush with a valid ORG held by a stalled slave
    k = 0;
    for (int c = 0; c < 8 && k < 5; c++) begin
      cycle(1'b1, rnd_pay(7 + k), 1'b0, 1'b0, 1'b0);
      if (in_if.ready) k++;
    end
    cycle(1'b1, rnd_pay(12), 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("flush_occ", occupancy, 0);
    chk("flush_org_id", out_if.id, 7);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_after_valid", out_if.valid, 0);
    idle_drain();

    // asynchronous reset between edges with requests queued
    k = 0;
    for (int c = 0; c < 8 && k < 6; c++) begin
      cycle(1'b1, rnd_pay(k), 1'b0, 1'b0, 1'b0);
      if (in_if.ready) k++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("areset");
    model_reset();
    in_if.valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("post_reset_valid", out_if.valid, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 3) != 0, rnd_pay(c), $urandom_range(0, 3) != 0,
            (m_ost > 0) && ($urandom_range(0, 2) == 0), $urandom_range(0, 60) == 0);
    end
    idle_drain();
    chk("sb_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ar_out_credit_buffer.md
Name: ar_out_credit_buffer

Overview:
- Next-generation outgoing AR buffer, placed between ar_id_ordering_unit and the AXI slave.
- Parametric-depth FIFO with a registered, AXI-stable output stage and a one-cycle bypass when empty.
- Adds outstanding-read credit throttling driven by read-burst completion, a synchronous flush, and occupancy / almost-full status for upstream backpressure.

Parameters:
- ID_WIDTH, 4, AR id width
- ADDR_WIDTH, 32, AR address width
- LEN_WIDTH, 8, AR len width
- SIZE_WIDTH, 3, AR size width
- BURST_WIDTH, 2, AR burst width
- QOS_WIDTH, 4, AR qos width
- DEPTH, 8, FIFO entries; any value >= 2, not required to be a power of two
- AFULL_THRESH, 6, occupancy at or above which almost_full asserts; range 1..DEPTH
- MAX_OUTSTANDING, 16, maximum loaded-but-not-completed reads; must be >= 1
- CNT_W (localparam) = $clog2(DEPTH+1); OST_W (localparam) = $clog2(MAX_OUTSTANDING+1)

Ports:
- clk  input  1  clock, all logic on posedge
- rst_n  input  1  asynchronous, active-low reset
- ar_in  ar_if.receiver  id/addr/len/size/burst/qos + valid/ready  AR requests from ar_id_ordering_unit
- ar_out  ar_if.sender  same fields  AR requests toward the AXI slave
- r_done  input  1  one-cycle pulse per completed read burst (slave R handshake with rlast)
- flush  input  1  synchronous discard of all FIFO entries
- buffer_full  output  1  occupancy == DEPTH
- buffer_almost_full  output  1  occupancy >= AFULL_THRESH
- occupancy  output  CNT_W  FIFO entry count; excludes the output register
- outstanding  output  OST_W  count of loaded-but-not-completed reads
- throttled  output  1  request waiting but blocked only by missing credit

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr, rd_ptr, occupancy, outstanding and out_valid_q all clear. ar_out.valid=0, ar_in.ready=0, all status outputs 0. Payload register contents are don't-care. Reset mid-burst drops every queued and in-register request with no partial state.
- ar_in.ready = rst_n & ~buffer_full & ~flush (combinational). push = ar_in.valid & ar_in.ready.
- Output register (ORG) drives all ar_out fields; ar_out.valid = out_valid_q.
  - Once valid is high, payload and valid hold stable until ar_out.ready; never withdrawn, including during flush.
- slot_free = ~out_valid_q | ar_out.ready. credit_ok = outstanding < MAX_OUTSTANDING. load = slot_free & credit_ok & (occupancy != 0 | push).
- Load source:
  - occupancy != 0: FIFO head at rd_ptr; rd_ptr advances and the pop counts toward occupancy.
  - occupancy == 0 and push: bypass, ar_in written directly into ORG; FIFO untouched.
  - Bypass latency: push at edge N makes ar_out.valid high after edge N. Otherwise a push is written to mem[wr_ptr].
- No load and slot_free with an accepted handshake: out_valid_q clears.
- Pointers wrap from DEPTH-1 to 0, so non-power-of-two DEPTH works.
- Occupancy updates: +1 on FIFO write only; -1 on FIFO pop only; unchanged when both occur.
- Full: ready is 0, so there is no same-cycle push at full, even when a pop happens.
- Credit counter:
  - outstanding +1 on load; -1 on r_done; unchanged when both occur.
  - r_done at outstanding==0 is ignored (no underflow); this is flagged by an assertion.
  - Consequence: the ORG entry already holds its credit, so the slave never sees more than MAX_OUTSTANDING reads issued but not completed.
- throttled = (occupancy != 0 | ar_in.valid) & slot_free & ~credit_ok.
- Flush (synchronous, one cycle): wr_ptr, rd_ptr and occupancy clear at the edge. No push or FIFO load occurs in the flush cycle. ORG and outstanding are unaffected.
- Ordering: strict FIFO; request order at ar_out equals acceptance order at ar_in.

Test Plan:
- Reset then single request: DEPTH=8, empty, ar_in.valid with addr 0x100, ar_out.ready=1 -> ar_out.valid=1 after 1 edge with addr 0x100; outstanding=1; occupancy stays 0.
- Fill and wrap: ar_out.ready=0, push 10 requests id 0..9 -> 1 in ORG, 8 in FIFO, buffer_full=1, ready=0, almost_full from occupancy 6. Then ready=1 with pushes continuing -> ids drain in order 0..N across pointer wrap; repeat with DEPTH=5.
- Credit throttle: MAX_OUTSTANDING=2, ar_out.ready=1, push 4 requests -> exactly 2 issued, throttled=1, outstanding=2. Each r_done pulse -> one more issue the next edge, order preserved.
- Simultaneous events: r_done together with load -> outstanding unchanged. Push together with pop at occupancy 3 -> occupancy stays 3. Stray r_done at outstanding 0 -> stays 0 and the assertion fires.
- Flush with valid ORG: 4 queued, ORG holding id 7, ar_out.ready=0, flush pulse -> occupancy=0, ar_in.ready=0 in the flush cycle. ORG still presents id 7 stable until ready; after it, no further valid.
- Async reset mid-operation: rst_n low between edges with 5 queued -> all outputs 0 immediately. After release, ar_in.ready=1 and no stale request appears on ar_out.
